qspi_mem_arb: RTL and testbench
===============================

# qspi_mem_arb

Two-port arbiter and transaction sequencer that shares the single QSPI memory engine inside `TOP` between the bfCPU instruction-fetch port (M0) and the data-tape port (M1). It accepts one read or write per requester, latches the winning request into registered slave-side signals, and waits for the QSPI engine's completion. It returns read data and a one-cycle acknowledge to the winner. A starvation counter guarantees instruction fetch forward progress under continuous data traffic.

## Interface
Parameters:
- `AW`, 24, address width (QSPI byte address)
- `DW`, 8, data width
- `STARVE_MAX`, 4, consecutive M1 grants allowed while M0 waits (1..15)
- `TIMEOUT`, 255, watchdog limit in cycles (only with `QSPI_ARB_TIMEOUT_EN`)

Ports (x = 0, 1):
- `CLK` in 1: the block's only clock.
- `RES_N` in 1: reset is synchronous and active-low.
- `Mx_REQ` in 1: request from master x. Held with fields stable until `Mx_ACK`.
- `Mx_WE` in 1: 1 = write, 0 = read.
- `Mx_ADDR` in AW: byte address.
- `Mx_WDATA` in DW: write data.
- `Mx_RDATA` out DW: read data, registered, valid while `Mx_ACK`=1.
- `Mx_ACK` out 1: one-cycle completion pulse.
- `S_REQ` out 1: request to the QSPI engine, registered.
- `S_WE` out 1: registered copy of the winner's `WE`.
- `S_ADDR` out AW: registered copy of the winner's `ADDR`.
- `S_WDATA` out DW: registered copy of the winner's `WDATA`.
- `S_RDATA` in DW: engine read data, valid with `S_ACK`.
- `S_ACK` in 1: one-cycle engine completion.
- `ERR` out 1: sticky watchdog error flag. Tied 0 without the macro.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, when some `Mx_REQ`=1:
  - Select the winner: M1 wins by default; M0 wins if only M0 requests, or if `starve_cnt` == `STARVE_MAX`.
  - Latch the winner's WE/ADDR/WDATA into the `S_*` registers.
  - Set `S_REQ`=1, record the winner, go to BUSY.
- BUSY: hold `S_REQ` and `S_*` stable until `S_ACK`=1 is sampled. Then:
  - Clear `S_REQ`.
  - Register `S_RDATA` into the winner's `RDATA`. On writes, `RDATA` is also loaded and its value is don't-care.
  - Set the winner's `ACK`=1 and go to DONE.
- DONE: the ACK pulse is high for this single cycle. No new grant is made. Return to IDLE.
- Masters must drop or replace `REQ` on the edge where they sample `ACK`=1. DONE ensures a stale `REQ` is never re-granted.
- `starve_cnt` (4 bits):
  - On an M1 grant while `M0_REQ`=1: increment, saturating at `STARVE_MAX`.
  - On an M0 grant: clear to 0.
  - On an M1 grant with `M0_REQ`=0: clear to 0.
- The non-winning `RDATA` holds its previous value. Only one `ACK` is ever high.
- `S_ACK` outside BUSY is ignored.

## Timing
- Reset (`RES_N`=0 sampled at an edge): state IDLE, `starve_cnt`=0. All outputs 0: `S_REQ`, `S_WE`, `S_ADDR`, `S_WDATA`, `Mx_ACK`, `Mx_RDATA`, `ERR`.
- Reset mid-transaction: `S_REQ` drops at the reset edge and no ACK is issued. The engine shares `RES_N`.
- `REQ` sampled in IDLE at edge N → `S_REQ`=1 after edge N.
- `S_ACK` sampled at edge K → `Mx_ACK`=1 and `S_REQ`=0 after edge K → IDLE after edge K+1.
- Best-case turnaround: request to ACK = engine latency + 2 cycles. Back-to-back grants are spaced at least 3 cycles apart.
- Simultaneous `M0_REQ` and `M1_REQ` in IDLE: resolved by the starvation rule only. There is no round-robin.

## Configuration
`QSPI_ARB_TIMEOUT_EN`:
- Defined:
  - An 8-bit-plus watchdog counts BUSY cycles.
  - Reaching `TIMEOUT` with no `S_ACK` does the following: clear `S_REQ`, ACK the winner with `RDATA`=all-ones, set `ERR`=1 (sticky until reset), go to DONE.
  - `S_ACK` in the same cycle as expiry is a normal completion, and `ERR` is not set.
- Undefined: no counter is built, BUSY waits indefinitely, and `ERR` is constant 0.

## Test plan
- Single M0 read of addr 0x000010 with the engine returning 0x3E after 20 cycles → `S_ADDR`=0x000010 and `S_WE`=0; `M0_RDATA`=0x3E with a 1-cycle `M0_ACK`; M1 outputs unchanged.
- M0 and M1 both request continuously, `STARVE_MAX`=4 → grant sequence M1,M1,M1,M1,M0,M1,M1,M1,M1,M0,…
- M1 write 0x5A to 0x000100 while M0 idle → `S_WE`=1 and `S_WDATA`=0x5A held through BUSY; `M1_ACK` pulse; `starve_cnt` stays 0.
- Master keeps `REQ` high through the ACK cycle, then drops it → exactly one engine transaction is issued.
- `RES_N`=0 during BUSY → `S_REQ`=0 and no ACK; a fresh request after release is granted normally.
- With `QSPI_ARB_TIMEOUT_EN`, `TIMEOUT`=16, and no `S_ACK` → ACK 17 cycles after `S_REQ` rises, `RDATA`=0xFF, `ERR`=1, and `ERR` stays 1 across later successful transactions.

Source files
------------

// File: rtl/qspi_mem_arb.sv
// qspi_mem_arb: shares the QSPI engine between fetch (M0) and data (M1).
// Optional watchdog on stalled engine: define QSPI_ARB_TIMEOUT_EN.
module qspi_mem_arb #(
  parameter int AW         = 24,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          CLK,
  input  logic          RES_N,
  input  logic          M0_REQ,
  input  logic          M0_WE,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [DW-1:0] M0_WDATA,
  output logic [DW-1:0] M0_RDATA,
  output logic          M0_ACK,
  input  logic          M1_REQ,
  input  logic          M1_WE,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [DW-1:0] M1_WDATA,
  output logic [DW-1:0] M1_RDATA,
  output logic          M1_ACK,
  output logic          S_REQ,
  output logic          S_WE,
  output logic [AW-1:0] S_ADDR,
  output logic [DW-1:0] S_WDATA,
  input  logic [DW-1:0] S_RDATA,
  input  logic          S_ACK,
  output logic          ERR
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_cfg_chk
    $error("qspi_mem_arb: STARVE_MAX must be 1..15, TIMEOUT >= 1");
  end

  state_t        r_state;
  state_t        w_next;
  logic          r_win0;
  logic [3:0]    r_starve;
  logic          r_s_req;
  logic          r_s_we;
  logic [AW-1:0] r_s_addr;
  logic [DW-1:0] r_s_wdata;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;
  logic          r_m0_ack;
  logic          r_m1_ack;
  logic          w_grant;
  logic          w_pick0;
  logic          w_cmpl;
  logic          w_tmo;
  logic          w_wdog_hit;
  logic [DW-1:0] w_rd;

`ifdef QSPI_ARB_TIMEOUT_EN
  localparam int TW =
    ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [TW-1:0] r_wdog;
  logic          r_err;

  assign w_wdog_hit = (r_wdog == TW'(TIMEOUT));
  assign ERR        = r_err;

  // Watchdog counts BUSY cycles; error flag is sticky until reset.
  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state != BUSY) r_wdog <= '0;
      else if (!w_wdog_hit) r_wdog <= r_wdog + 1'b1;
      if (w_tmo) r_err <= 1'b1;
    end
  end
`else
  assign w_wdog_hit = 1'b0;
  assign ERR        = 1'b0;
`endif

  assign w_rd = w_tmo ? '1 : S_RDATA;

  // Next state plus grant/complete strobes; S_ACK wins over expiry.
  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_pick0 = 1'b0;
    w_cmpl  = 1'b0;
    w_tmo   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (M0_REQ || M1_REQ) begin
          w_grant = 1'b1;
          w_pick0 = M0_REQ && (!M1_REQ || r_starve == SMAX);
          w_next  = BUSY;
        end
      end
      BUSY: begin
        if (S_ACK) begin
          w_cmpl = 1'b1;
          w_next = DONE;
        end else if (w_wdog_hit) begin
          w_tmo  = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, latched engine request, starvation count and master returns.
  always_ff @(posedge CLK) begin
    if (!RES_N) begin
      r_state    <= IDLE;
      r_win0     <= 1'b0;
      r_starve   <= '0;
      r_s_req    <= 1'b0;
      r_s_we     <= 1'b0;
      r_s_addr   <= '0;
      r_s_wdata  <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      if (w_grant) begin
        r_win0    <= w_pick0;
        r_s_req   <= 1'b1;
        r_s_we    <= w_pick0 ? M0_WE : M1_WE;
        r_s_addr  <= w_pick0 ? M0_ADDR : M1_ADDR;
        r_s_wdata <= w_pick0 ? M0_WDATA : M1_WDATA;
        if (w_pick0 || !M0_REQ) r_starve <= '0;
        else if (r_starve != SMAX) r_starve <= r_starve + 4'd1;
      end
      if (w_cmpl || w_tmo) begin
        r_s_req <= 1'b0;
        if (r_win0) begin
          r_m0_rdata <= w_rd;
          r_m0_ack   <= 1'b1;
        end else begin
          r_m1_rdata <= w_rd;
          r_m1_ack   <= 1'b1;
        end
      end
    end
  end

  assign S_REQ    = r_s_req;
  assign S_WE     = r_s_we;
  assign S_ADDR   = r_s_addr;
  assign S_WDATA  = r_s_wdata;
  assign M0_RDATA = r_m0_rdata;
  assign M1_RDATA = r_m1_rdata;
  assign M0_ACK   = r_m0_ack;
  assign M1_ACK   = r_m1_ack;

endmodule

// File: tb/tb_qspi_mem_arb.sv
// tb_qspi_mem_arb: directed bench for the QSPI memory arbiter.
// Engine side is driven by hand from the stimulus sequence.
module tb_qspi_mem_arb;
  localparam int AW = 24;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RES_N = 1'b0;
  logic          M0_REQ = 1'b0, M0_WE = 1'b0;
  logic [AW-1:0] M0_ADDR = '0;
  logic [DW-1:0] M0_WDATA = '0;
  logic [DW-1:0] M0_RDATA;
  logic          M0_ACK;
  logic          M1_REQ = 1'b0, M1_WE = 1'b0;
  logic [AW-1:0] M1_ADDR = '0;
  logic [DW-1:0] M1_WDATA = '0;
  logic [DW-1:0] M1_RDATA;
  logic          M1_ACK;
  logic          S_REQ, S_WE;
  logic [AW-1:0] S_ADDR;
  logic [DW-1:0] S_WDATA;
  logic [DW-1:0] S_RDATA = '0;
  logic          S_ACK = 1'b0;
  logic          ERR;

  int n_chk = 0;
  int n_pass = 0;
  int n_rise = 0;
  logic prev_sreq = 1'b0;

  always #5 CLK = ~CLK;

  qspi_mem_arb #(
    .AW(AW), .DW(DW), .STARVE_MAX(4), .TIMEOUT(16)
  ) dut (
    .CLK(CLK), .RES_N(RES_N),
    .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR),
    .M0_WDATA(M0_WDATA), .M0_RDATA(M0_RDATA), .M0_ACK(M0_ACK),
    .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR),
    .M1_WDATA(M1_WDATA), .M1_RDATA(M1_RDATA), .M1_ACK(M1_ACK),
    .S_REQ(S_REQ), .S_WE(S_WE), .S_ADDR(S_ADDR),
    .S_WDATA(S_WDATA), .S_RDATA(S_RDATA), .S_ACK(S_ACK),
    .ERR(ERR)
  );

  always @(posedge CLK) begin
    if (S_REQ && !prev_sreq) n_rise++;
    prev_sreq = S_REQ;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sack(input logic [DW-1:0] d);
    S_ACK = 1'b1;
    S_RDATA = d;
    tick();
    S_ACK = 1'b0;
  endtask

  initial begin
    int c;
    int n0;
    bit exp0;

    // reset state
    tick();
    tick();
    chk("rst_sreq", S_REQ, 0);
    chk("rst_swe", S_WE, 0);
    chk("rst_saddr", S_ADDR, 0);
    chk("rst_swdata", S_WDATA, 0);
    chk("rst_acks", {M0_ACK, M1_ACK}, 0);
    chk("rst_m0rd", M0_RDATA, 0);
    chk("rst_m1rd", M1_RDATA, 0);
    chk("rst_err", ERR, 0);
    RES_N = 1'b1;
    tick();

    // single M0 read, engine latency 20
    M0_REQ = 1'b1; M0_WE = 1'b0; M0_ADDR = 24'h000010;
    tick();
    chk("rd_sreq", S_REQ, 1);
    chk("rd_saddr", S_ADDR, 24'h000010);
    chk("rd_swe", S_WE, 0);
    for (int i = 0; i < 19; i++) tick();
    chk("rd_hold", {S_REQ, M0_ACK}, 2'b10);
    sack(8'h3E);
    M0_REQ = 1'b0;
    chk("rd_ack", {M0_ACK, M1_ACK}, 2'b10);
    chk("rd_data", M0_RDATA, 8'h3E);
    chk("rd_m1rd", M1_RDATA, 0);
    chk("rd_sreq_clr", S_REQ, 0);
    tick();
    chk("rd_pulse", M0_ACK, 0);
    chk("rd_keep", M0_RDATA, 8'h3E);

    // M1 write, M0 idle
    M1_REQ = 1'b1; M1_WE = 1'b1;
    M1_ADDR = 24'h000100; M1_WDATA = 8'h5A;
    tick();
    chk("wr_sreq", S_REQ, 1);
    chk("wr_saddr", S_ADDR, 24'h000100);
    chk("wr_swe", S_WE, 1);
    chk("wr_swd", S_WDATA, 8'h5A);
    M1_WDATA = 8'h00;
    for (int i = 0; i < 3; i++) tick();
    chk("wr_hold", {S_REQ, S_WE, S_WDATA}, {2'b11, 8'h5A});
    sack(8'h77);
    M1_REQ = 1'b0; M1_WE = 1'b0;
    chk("wr_ack", {M0_ACK, M1_ACK}, 2'b01);
    chk("wr_m0keep", M0_RDATA, 8'h3E);
    tick();

    // both masters continuous: M1 x4 then M0
    M0_REQ = 1'b1; M0_ADDR = 24'h000AAA;
    M1_REQ = 1'b1; M1_ADDR = 24'h000BBB;
    for (int g = 0; g < 10; g++) begin
      c = 0;
      while (!S_REQ && c < 8) begin
        tick();
        c++;
      end
      if (g > 0) chk($sformatf("st_gap%0d", g), c, 2);
      exp0 = (g % 5 == 4);
      chk($sformatf("st_win%0d", g), S_ADDR,
          exp0 ? 24'h000AAA : 24'h000BBB);
      sack(8'(g + 8'h40));
      chk($sformatf("st_ack%0d", g), {M0_ACK, M1_ACK},
          exp0 ? 2'b10 : 2'b01);
    end
    M0_REQ = 1'b0; M1_REQ = 1'b0;
    chk("st_m0rd", M0_RDATA, 8'h49);
    chk("st_m1rd", M1_RDATA, 8'h48);
    tick();
    tick();

    // REQ held through the ACK cycle: one transaction only
    n0 = n_rise;
    M0_REQ = 1'b1; M0_ADDR = 24'h000020;
    tick();
    sack(8'h21);
    chk("hold_ack", M0_ACK, 1);
    tick();
    M0_REQ = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("hold_sreq", S_REQ, 0);
    chk("hold_once", n_rise - n0, 1);

    // reset during BUSY
    M1_REQ = 1'b1; M1_ADDR = 24'h000300;
    tick();
    chk("rb_sreq", S_REQ, 1);
    tick();
    tick();
    RES_N = 1'b0; M1_REQ = 1'b0;
    tick();
    chk("rb_sreq_clr", S_REQ, 0);
    chk("rb_noack", {M0_ACK, M1_ACK}, 0);
    RES_N = 1'b1;
    sack(8'h99);
    chk("rb_ign", {M0_ACK, M1_ACK, S_REQ}, 0);
    tick();
    chk("rb_ign2", {M0_ACK, M1_ACK}, 0);
    M0_REQ = 1'b1; M0_ADDR = 24'h000040;
    tick();
    chk("rb_new", {S_REQ, S_ADDR}, {1'b1, 24'h000040});
    sack(8'hC3);
    M0_REQ = 1'b0;
    chk("rb_ack", {M0_ACK, M0_RDATA}, {1'b1, 8'hC3});
    tick();
    tick();

`ifdef QSPI_ARB_TIMEOUT_EN
    // watchdog expiry with no engine response
    M1_REQ = 1'b1; M1_ADDR = 24'h000500;
    tick();
    chk("to_sreq", S_REQ, 1);
    c = 0;
    while (!M1_ACK && c < 40) begin
      tick();
      c++;
    end
    M1_REQ = 1'b0;
    chk("to_lat", c, 17);
    chk("to_rd", M1_RDATA, 8'hFF);
    chk("to_err", ERR, 1);
    chk("to_sreq_clr", S_REQ, 0);
    tick();
    M0_REQ = 1'b1; M0_ADDR = 24'h000600;
    tick();
    sack(8'h11);
    M0_REQ = 1'b0;
    chk("to_ok", {M0_ACK, M0_RDATA}, {1'b1, 8'h11});
    chk("to_sticky", ERR, 1);
    tick();
`else
    chk("err_off", ERR, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
